// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - oversampled I2C target with address match, write capture and read return
//
// Ports:
//   clk, rst   system clock; asynchronous active-high reset
//   own_addr   7-bit target address, compared when the address byte completes
//   scl_in     bus SCL (asynchronous, synchronized here)
//   sda_in     bus SDA (asynchronous, synchronized here)
//   sda_out    open-drain SDA drive: 0 pulls low, 1 releases
//   data_snt   read data, byte0 in the top byte, latched when the read address matches
//   data_rcv   write data, byte0 in the top byte; unwritten bytes keep their value
//   rcv_valid  one-cycle pulse when a write of >=1 byte ends with STOP or Sr
//   rcv_count  number of bytes accepted by that write
//   busy       high from START until STOP

module i2c_target_responder #(
  parameter int  NUM_BYTES   = 3,
  parameter int  SYNC_STAGES = 2,
  localparam int DW          = 8 * NUM_BYTES,
  localparam int CNT_W       = $clog2(NUM_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       own_addr,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_out,
  input  logic [DW-1:0]    data_snt,
  output logic [DW-1:0]    data_rcv,
  output logic             rcv_valid,
  output logic [CNT_W-1:0] rcv_count,
  output logic             busy
);

  localparam logic [CNT_W-1:0] NB = CNT_W'(NUM_BYTES);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   s_scl, s_sda;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  assign s_scl = scl_sync[SYNC_STAGES-1];
  assign s_sda = sda_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= s_scl;
      sda_d    <= s_sda;
    end
  end

  assign scl_rise  = s_scl & ~scl_d;
  assign scl_fall  = ~s_scl & scl_d;
  // SCL must be high in both samples, so an SDA edge coinciding with an
  // SCL edge is an ordinary data change rather than START/STOP.
  assign start_det = ~s_sda & sda_d & s_scl & scl_d;
  assign stop_det  = s_sda & ~sda_d & s_scl & scl_d;

  state_t           state;
  logic [3:0]       bit_cnt;    // SCL rises seen in the current 9-clock frame
  logic [6:0]       shreg;
  logic             rw;
  logic             ack_ok;     // ACK verdict for the write byte just received
  logic             wr_xfer;    // current transfer is an addressed write
  logic [CNT_W-1:0] byte_cnt;
  logic [DW-1:0]    tx_buf;     // read bytes still to send, refilled with 0xFF
  logic [7:0]       rd_shreg;   // remaining bits of the byte being sent
  logic [7:0]       rx_byte;

  assign rx_byte = {shreg, s_sda};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sda_out   <= 1'b1;
      data_rcv  <= '0;
      rcv_valid <= 1'b0;
      rcv_count <= '0;
      busy      <= 1'b0;
      bit_cnt   <= 4'd0;
      shreg     <= 7'd0;
      rw        <= 1'b0;
      ack_ok    <= 1'b0;
      wr_xfer   <= 1'b0;
      byte_cnt  <= '0;
      tx_buf    <= '0;
      rd_shreg  <= 8'hFF;
    end else begin
      rcv_valid <= 1'b0;
      if (state != IDLE && (stop_det || start_det)) begin
        if (wr_xfer && byte_cnt != '0) begin
          rcv_valid <= 1'b1;
          rcv_count <= byte_cnt;
        end
        sda_out  <= 1'b1;
        bit_cnt  <= 4'd0;
        byte_cnt <= '0;
        wr_xfer  <= 1'b0;
        if (stop_det) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          state <= ADDR;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start_det) begin
              state    <= ADDR;
              busy     <= 1'b1;
              bit_cnt  <= 4'd0;
              byte_cnt <= '0;
              wr_xfer  <= 1'b0;
            end
          end

          ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (shreg == own_addr) begin
                  state   <= ADDR_ACK;
                  rw      <= s_sda;
                  wr_xfer <= ~s_sda;
                  if (s_sda) tx_buf <= data_snt;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end

          ADDR_ACK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd9;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_out <= 1'b0;
              end else if (bit_cnt == 4'd9) begin
                bit_cnt <= 4'd0;
                if (rw) begin
                  state    <= RD_DATA;
                  sda_out  <= tx_buf[DW-1];
                  rd_shreg <= {tx_buf[DW-2 -: 7], 1'b1};
                  tx_buf   <= (tx_buf << 8) | {{(DW-8){1'b0}}, 8'hFF};
                end else begin
                  state   <= WR_DATA;
                  sda_out <= 1'b1;
                end
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state <= WR_ACK;
                if (byte_cnt < NB) begin
                  data_rcv[DW-1-8*int'(byte_cnt) -: 8] <= rx_byte;
                  byte_cnt <= byte_cnt + CNT_W'(1);
                  ack_ok   <= 1'b1;
                end else begin
                  ack_ok <= 1'b0;
                end
              end
            end
          end

          WR_ACK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd9;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_out <= ~ack_ok;
              end else if (bit_cnt == 4'd9) begin
                sda_out <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= ack_ok ? WR_DATA : WAIT_STOP;
              end
            end
          end

          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_out <= 1'b1;
                state   <= RD_ACK;
              end else begin
                sda_out  <= rd_shreg[7];
                rd_shreg <= {rd_shreg[6:0], 1'b1};
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (s_sda) state <= WAIT_STOP;
              else       bit_cnt <= 4'd9;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              state    <= RD_DATA;
              bit_cnt  <= 4'd0;
              sda_out  <= tx_buf[DW-1];
              rd_shreg <= {tx_buf[DW-2 -: 7], 1'b1};
              tx_buf   <= (tx_buf << 8) | {{(DW-8){1'b0}}, 8'hFF};
            end
          end

          WAIT_STOP: sda_out <= 1'b1;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// tb/tb_i2c_target_responder.sv - bench for i2c_target_responder

module tb_i2c_target_responder;

  localparam int Q = 6;  // clocks per quarter SCL period

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  own_addr;
  logic        scl_m, sda_m;
  logic        sda_in;
  logic        sda_out;
  logic [23:0] data_snt, data_rcv;
  logic        rcv_valid;
  logic [1:0]  rcv_count;
  logic        busy;

  assign sda_in = sda_m & sda_out;  // wired-AND bus

  always #5 clk = ~clk;

  i2c_target_responder dut (
    .clk      (clk),
    .rst      (rst),
    .own_addr (own_addr),
    .scl_in   (scl_m),
    .sda_in   (sda_in),
    .sda_out  (sda_out),
    .data_snt (data_snt),
    .data_rcv (data_rcv),
    .rcv_valid(rcv_valid),
    .rcv_count(rcv_count),
    .busy     (busy)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic [6:0]  own;
    logic [7:0]  addr_byte;
    int          nbytes;
    logic [31:0] wdata;
    logic [23:0] snt;
    logic [3:0]  m_nack;
    logic [4:0]  exp_ack;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic [23:0] exp_rcv;
    logic [1:0]  exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [23:0] d;
    logic [1:0]  c;
  } rcv_t;

  vec_t        vecs[8];
  logic        ack_q[$];
  logic [7:0]  rd_q[$];
  rcv_t        rcv_q[$];

  int n_vec = 0, n_err = 0;
  int pulse_cnt = 0, low_seen = 0, hi_toggle = 0, hi_cnt = 0;
  logic watch_low = 1'b0;
  logic sda_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; q_wait(); scl_m = 1'b1; q_wait(); q_wait(); scl_m = 1'b0; q_wait();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; q_wait(); scl_m = 1'b1; q_wait(); b = sda_in; q_wait(); scl_m = 1'b0; q_wait();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
  endtask

  task automatic get_byte(output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      get_bit(x);
      b[i] = x;
    end
  endtask

  task automatic start_cond();
    sda_m = 1'b1; scl_m = 1'b1; q_wait(); sda_m = 1'b0; q_wait(); scl_m = 1'b0; q_wait();
  endtask

  task automatic rstart_cond();
    sda_m = 1'b1; q_wait(); scl_m = 1'b1; q_wait(); sda_m = 1'b0; q_wait(); scl_m = 1'b0; q_wait();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; q_wait(); scl_m = 1'b1; q_wait(); sda_m = 1'b1; q_wait(); q_wait();
  endtask

  task automatic run_vec(input vec_t v, input bit do_start, input bit do_stop);
    logic       b;
    logic [7:0] by;
    own_addr = v.own;
    data_snt = v.snt;
    watch_low = v.exp_ack[0];
    low_seen = 0;
    if (do_start) begin
      start_cond();
      check({v.name, "_busy"}, busy, 1);
    end
    ack_q.push_back(v.exp_ack[0]);
    send_byte(v.addr_byte);
    get_bit(b);
    check({v.name, "_addr_ack"}, b, ack_q.pop_front());
    for (int i = 0; i < v.nbytes; i++) begin
      if (!v.rd) begin
        ack_q.push_back(v.exp_ack[i+1]);
        send_byte(v.wdata[31-8*i -: 8]);
        get_bit(b);
        check($sformatf("%s_ack%0d", v.name, i), b, ack_q.pop_front());
      end else begin
        rd_q.push_back(v.exp_rd[31-8*i -: 8]);
        get_byte(by);
        check($sformatf("%s_byte%0d", v.name, i), by, rd_q.pop_front());
        put_bit(v.m_nack[i]);
        if (v.m_nack[i]) check({v.name, "_release"}, sda_out, 1);
      end
    end
    if (v.exp_valid) rcv_q.push_back('{d: v.exp_rcv, c: v.exp_cnt});
    if (v.exp_ack[0]) check({v.name, "_no_drive"}, low_seen, 0);
    watch_low = 1'b0;
    if (do_stop) begin
      stop_cond();
      check({v.name, "_idle"}, busy, 0);
    end
  endtask

  // Receive-side monitor: every rcv_valid pulse must match the next expected write.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b0 && rcv_valid === 1'b1) begin
      rcv_t e;
      pulse_cnt++;
      if (rcv_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rcv_unexpected: got data 0x%0h count %0d, expected no pulse", data_rcv, rcv_count);
      end else begin
        e = rcv_q.pop_front();
        check("rcv_data", data_rcv, e.d);
        check("rcv_count", rcv_count, e.c);
      end
      @(negedge clk);
      check("rcv_valid_width", rcv_valid, 0);
    end
  end

  always @(negedge clk) begin
    if (watch_low && sda_out === 1'b0) low_seen <= low_seen + 1;
    hi_cnt   <= scl_m ? hi_cnt + 1 : 0;
    sda_prev <= sda_out;
    if (!rst && scl_m && hi_cnt > 2 && sda_out !== sda_prev) hi_toggle <= hi_toggle + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   pc;
    logic b;

    vecs[0] = '{"wr3",       0, 7'h2A, 8'h54, 3, 32'hA53C7E00, 24'h0,      4'b0000, 5'b00000, 32'h0,        1, 24'hA53C7E, 2'd3};
    vecs[1] = '{"rd3",       1, 7'h2A, 8'h55, 3, 32'h0,        24'h123456, 4'b0100, 5'b00000, 32'h12345600, 0, 24'h0,      2'd0};
    vecs[2] = '{"nomatch",   0, 7'h2A, 8'h56, 2, 32'h99880000, 24'h0,      4'b0000, 5'b00111, 32'h0,        0, 24'h0,      2'd0};
    vecs[3] = '{"wr4",       0, 7'h2A, 8'h54, 4, 32'h11223344, 24'h0,      4'b0000, 5'b10000, 32'h0,        1, 24'h112233, 2'd3};
    vecs[4] = '{"rd4_pad",   1, 7'h2A, 8'h55, 4, 32'h0,        24'hC3A55A, 4'b1000, 5'b00000, 32'hC3A55AFF, 0, 24'h0,      2'd0};
    vecs[5] = '{"wr1_a7f",   0, 7'h7F, 8'hFE, 1, 32'h5C000000, 24'h0,      4'b0000, 5'b00000, 32'h0,        1, 24'h5C2233, 2'd1};
    vecs[6] = '{"wr0",       0, 7'h2A, 8'h54, 0, 32'h0,        24'h0,      4'b0000, 5'b00000, 32'h0,        0, 24'h0,      2'd0};
    vecs[7] = '{"rd_nomatch",1, 7'h10, 8'h55, 1, 32'h0,        24'h0,      4'b0001, 5'b00001, 32'hFF000000, 0, 24'h0,      2'd0};

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; own_addr = 7'h2A; data_snt = 24'h0;
    repeat (3) @(negedge clk);
    check("rst_sda_out", sda_out, 1);
    check("rst_data_rcv", data_rcv, 0);
    check("rst_rcv_valid", rcv_valid, 0);
    check("rst_rcv_count", rcv_count, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 1, 1);

    // write one byte, then repeated START into a read
    v = '{"sr_wr", 0, 7'h2A, 8'h54, 1, 32'hAB000000, 24'h0, 4'b0000, 5'b00000, 32'h0, 1, 24'hAB2233, 2'd1};
    run_vec(v, 1, 0);
    pc = pulse_cnt;
    rstart_cond();
    check("sr_pulse", pulse_cnt, pc + 1);
    check("sr_busy", busy, 1);
    v = '{"sr_rd", 1, 7'h2A, 8'h55, 2, 32'h0, 24'h0F1E2D, 4'b0010, 5'b00000, 32'h0F1E0000, 0, 24'h0, 2'd0};
    run_vec(v, 0, 1);

    // reset while the target is pulling SDA low in a read
    own_addr = 7'h2A;
    data_snt = 24'h000000;
    start_cond();
    send_byte(8'h55);
    get_bit(b);
    check("mid_addr_ack", b, 0);
    for (int i = 0; i < 4; i++) get_bit(b);
    check("mid_pre_low", sda_out, 0);
    check("mid_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sda", sda_out, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", data_rcv, 0);
    check("mid_rst_count", rcv_count, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sda_m = 1'b1;
    q_wait();
    scl_m = 1'b1;
    q_wait();
    v = '{"post_rst", 0, 7'h2A, 8'h54, 1, 32'h3C000000, 24'h0, 4'b0000, 5'b00000, 32'h0, 1, 24'h3C0000, 2'd1};
    run_vec(v, 1, 1);

    repeat (4) @(negedge clk);
    check("rcv_q_drained", rcv_q.size(), 0);
    check("sda_stable_scl_high", hi_toggle, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
